mem_ctrl: RTL

- Arbitrates the CPU's single byte-wide external memory port between instruction fetch (IF) and data access (MEM stage).
- Serialises 1/2/4-byte transactions into per-byte RAM cycles.
- Assembles and disassembles little-endian words.
- Honours the global rdy pause; sits between the pipeline stages and the cpu top-level mem_din/mem_dout/mem_addr/mem_wr pins.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_ctrl_if.sv | 27 ++
 rtl/mem_byte_asm.sv | 20 ++
 rtl/mem_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the byte-wide memory controller.
package mem_ctrl_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam logic [1:0] IO_SEL = 2'b11;
  localparam logic [1:0] MEM_LEN_BYTE = 2'b00;
  localparam logic [1:0] MEM_LEN_HALF = 2'b01;
  localparam logic [1:0] MEM_LEN_WORD = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD = 2'd1;
  localparam logic [1:0] ST_WR = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic {OWN_IF, OWN_MEM} owner_e;
  // 2'b10 is illegal and falls through to a full word
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == MEM_LEN_BYTE ? 3'd1 : len == MEM_LEN_HALF ? 3'd2 : 3'd4;
  endfunction
  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
    return a[17:16] == IO_SEL;
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: pipeline request/response and external RAM byte bus.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;
  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_len;
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [31:0]           mem_wdata;
  logic                  mem_done;
  logic [31:0]           mem_rdata;
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr_i, mem_wdata, ram_din,
    output if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr_i, mem_wdata, ram_din,
    input  if_done, if_data, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_byte_asm.sv
// mem_byte_asm: little-endian word assembler; o_word already includes the byte being captured.
module mem_byte_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [1:0]  i_lane,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word
);
  logic [31:0] r_word;
  always_comb begin
    o_word = r_word;
    for (int i = 0; i < 4; i++)
      if (i_lane == 2'(i)) o_word[8*i +: 8] = i_byte;
  end
  always_ff @(posedge clk)
    if (rst || i_clr) r_word <= '0;
    else if (i_en) r_word <= o_word;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM onto one byte-wide RAM port, serialising 1/2/4-byte transfers.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic flush,
  output logic busy,
  mem_ctrl_if.slave bus
);
  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [2:0]            r_n;
  owner_e                r_own;
  logic [31:0]           r_wdata;
  logic [2:0]            r_issue;
  logic [1:0]            r_cap;
  logic                  r_vld;
  logic                  r_rdy_q;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [7:0]            r_dout;
  logic                  r_wr;
  logic                  r_if_done;
  logic                  r_mem_done;
  logic [31:0]           r_if_data;
  logic [31:0]           r_mem_rdata;
  logic                  w_take_mem;
  logic                  w_take_if;
  logic                  w_accept;
  logic                  w_cap;
  logic                  w_last;
  logic                  w_if_kill;
  logic [31:0]           w_word;
  logic [7:0]            w_wbyte;
  assign w_take_mem = bus.mem_req;
  assign w_take_if  = bus.if_req && !flush;
  assign w_accept   = r_state == ST_IDLE && (w_take_mem || w_take_if);
  assign w_if_kill  = flush && r_own == OWN_IF;
  // r_vld: ram_din holds the byte for lane r_cap; r_rdy_q low marks the re-issue edge after a pause
  assign w_cap  = r_state == ST_RD && r_vld && r_rdy_q;
  assign w_last = w_cap && {1'b0, r_cap} == r_n - 3'd1;
  assign w_wbyte = r_issue[1] ? (r_issue[0] ? r_wdata[31:24] : r_wdata[23:16])
                              : (r_issue[0] ? r_wdata[15:8]  : r_wdata[7:0]);
  mem_byte_asm u_asm (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (rdy && w_accept),
    .i_en   (rdy && w_cap),
    .i_lane (r_cap),
    .i_byte (bus.ram_din),
    .o_word (w_word)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_n         <= '0;
      r_own       <= OWN_IF;
      r_wdata     <= '0;
      r_issue     <= '0;
      r_cap       <= '0;
      r_vld       <= 1'b0;
      r_rdy_q     <= 1'b1;
      r_a         <= '0;
      r_dout      <= '0;
      r_wr        <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_rdy_q <= rdy;
      if (rdy) begin
        r_if_done  <= 1'b0;
        r_mem_done <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            r_issue <= 3'd1;
            r_cap   <= '0;
            r_vld   <= 1'b0;
            if (w_take_mem) begin
              r_base  <= bus.mem_addr_i;
              r_a     <= bus.mem_addr_i;
              r_n     <= len_bytes(bus.mem_len);
              r_own   <= OWN_MEM;
              r_wdata <= bus.mem_wdata;
              r_dout  <= bus.mem_wdata[7:0];
              r_wr    <= bus.mem_we;
              r_state <= bus.mem_we ? ST_WR : ST_RD;
            end else if (w_take_if) begin
              r_base  <= bus.if_addr;
              r_a     <= bus.if_addr;
              r_n     <= 3'd4;
              r_own   <= OWN_IF;
              r_wr    <= 1'b0;
              r_state <= ST_RD;
            end
          end
          ST_RD: begin
            if (w_if_kill) r_state <= ST_IDLE;
            else if (!r_rdy_q) begin
              r_a     <= r_base + ADDR_WIDTH'(r_cap);
              r_issue <= {1'b0, r_cap} + 3'd1;
              r_vld   <= 1'b0;
            end else begin
              r_vld <= 1'b1;
              if (r_issue < r_n) begin
                r_a     <= r_base + ADDR_WIDTH'(r_issue);
                r_issue <= r_issue + 3'd1;
              end
              if (w_cap) r_cap <= r_cap + 2'd1;
              if (w_last) begin
                r_state <= ST_DONE;
                if (r_own == OWN_MEM) begin
                  r_mem_done  <= 1'b1;
                  r_mem_rdata <= w_word;
                end else begin
                  r_if_done <= 1'b1;
                  r_if_data <= w_word;
                end
              end
            end
          end
          ST_WR: begin
            if (r_issue < r_n) begin
              r_a     <= r_base + ADDR_WIDTH'(r_issue);
              r_dout  <= w_wbyte;
              r_issue <= r_issue + 3'd1;
            end else begin
              r_wr       <= 1'b0;
              r_mem_done <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
  assign busy          = r_state != ST_IDLE;
  assign bus.ram_a     = r_a;
  assign bus.ram_dout  = r_dout;
  assign bus.ram_wr    = r_wr && rdy;
  assign bus.if_done   = r_if_done;
  assign bus.if_data   = r_if_data;
  assign bus.mem_done  = r_mem_done;
  assign bus.mem_rdata = r_mem_rdata;
endmodule
